delay_line_prog: RTL and testbench
==================================

// Module: delay_line_prog
//
// PURPOSE
//   Runtime-programmable, multi-bit delay line with clock-enable, flush and per-sample valid tracking.
//   Replaces fixed single-bit delay pipes where the same pipeline must align differently-latent paths
//   (e.g. sync/colour/pixel alignment) selected at run time.
//   Sits between a producer and a consumer on one clock domain; output is tapped from a shift chain.
//
// PARAMETERS
//   WIDTH      8    data bits per sample (>=1)
//   MAX_DELAY  4    deepest selectable delay in enabled cycles (>=1); number of storage stages
//   RESET_VAL  '0   WIDTH-bit value loaded into every data stage on reset/flush
//
// PORTS
//   clk_i     in   1                       clock, all state on rising edge
//   rst_i     in   1                       reset, synchronous, active-high
//   en_i      in   1                       advance enable; 0 = whole chain holds
//   flush_i   in   1                       synchronous clear of all stages (data and valid)
//   delay_i   in   $clog2(MAX_DELAY+1)     selected delay N, 0..MAX_DELAY
//   data_i    in   WIDTH                   input sample
//   valid_i   in   1                       input sample qualifier
//   data_o    out  WIDTH                   delayed sample
//   valid_o   out  1                       delayed qualifier
//
// BEHAVIOUR
//   - Storage: MAX_DELAY stages S[1..MAX_DELAY], each {valid, data}. S[k] is the sample captured k enabled edges ago.
//   - Priority per edge: rst_i > flush_i > en_i.
//   - rst_i=1 at an edge: all S[k].data <= RESET_VAL, all S[k].valid <= 0.
//   - flush_i=1 (rst_i=0) at an edge: same clear as reset, regardless of en_i.
//     The sample on data_i/valid_i that cycle is discarded.
//   - en_i=1, no rst/flush: S[1] <= {valid_i, data_i}; S[k] <= S[k-1] for k=2..MAX_DELAY.
//   - en_i=0, no rst/flush: all stages hold; outputs stay constant unless delay_i changes.
//   - Output tap (combinational from stages):
//     N = (delay_i > MAX_DELAY) ? MAX_DELAY : delay_i  (saturate, never index out of range).
//     N=0 -> data_o=data_i, valid_o=valid_i (combinational bypass, zero latency).
//     N>=1 -> data_o=S[N].data, valid_o=S[N].valid.
//   - Latency: with en_i held 1, a sample presented at cycle t appears on data_o at cycle t+N.
//     Stalled cycles (en_i=0) do not count.
//   - Output reset values: after reset with N>=1, data_o=RESET_VAL, valid_o=0.
//     With N=0 the outputs follow the inputs.
//   - Fill: after reset/flush, valid_o first rises N enabled edges after the first valid_i=1 sample is captured.
//     Bubbles (valid_i=0) propagate as valid=0 stages.
//   - delay_i change: takes effect the same cycle (pure tap move), no state disturbed.
//     Increasing N exposes older stored samples; stages never written since reset/flush show valid_o=0.
//     Decreasing N skips samples, which are not replayed.
//   - WIDTH=1, MAX_DELAY=D, delay_i=D, en_i=1 reproduces a plain D-cycle delay.
//   - No X propagation: all stages are explicitly reset; delay_i is the only tap select.
//
// TESTING
//   1 Reset: rst_i=1 for 2 cycles, delay_i=3 -> data_o=RESET_VAL, valid_o=0; hold with en_i=1 and valid_i=0 -> unchanged.
//   2 Latency sweep: for N=0..MAX_DELAY, drive a counter 1,2,3.. with valid_i=1 and en_i=1
//     -> data_o at cycle t equals the input from cycle t-N; N=0 is same-cycle; delay_i=7 behaves as MAX_DELAY=4.
//   3 Stall: N=2, inputs A,B then en_i=0 for 3 cycles (inputs C,D,E ignored) then en_i=1 with F
//     -> outputs A (held across stall), then B, then F; C,D,E never appear.
//   4 Flush: N=3, chain full of valid samples, flush_i=1 with en_i=1 and input X
//     -> next cycle valid_o=0 and data_o=RESET_VAL; X never appears; first valid sample after flush is out 3 cycles later.
//   5 Runtime retap: N=1 with stream 10,11,12,.. and valid_i=1 since reset; at cycle 6 set N=4
//     -> same cycle data_o jumps to the sample 4 back; set N=4 at cycle 2 instead -> valid_o=0 until stage 4 is filled.
//   6 Priority: rst_i and flush_i both 1 with en_i=1 -> all cleared; flush_i=1 with en_i=0 -> still cleared.

Source files
------------

// File: rtl/delay_line_prog_if.sv
// Producer/consumer bundle for the programmable delay line.
// The master side drives the sample, its qualifier and the controls; the slave side returns the delayed tap.
interface delay_line_prog_if #(
  parameter int WIDTH   = 8,
  parameter int DELAY_W = 3
);
  logic               en_i;
  logic               flush_i;
  logic [DELAY_W-1:0] delay_i;
  logic [WIDTH-1:0]   data_i;
  logic               valid_i;
  logic [WIDTH-1:0]   data_o;
  logic               valid_o;

  modport master (
    output en_i, flush_i, delay_i, data_i, valid_i,
    input  data_o, valid_o
  );

  modport slave (
    input  en_i, flush_i, delay_i, data_i, valid_i,
    output data_o, valid_o
  );
endinterface

// File: rtl/delay_line_prog.sv
// Runtime-programmable delay line: a MAX_DELAY-deep {valid, data} shift chain with a saturating output tap.
// Tap 0 is a combinational bypass; moving the tap never disturbs the stored stages.
module delay_line_prog #(
  parameter int               WIDTH     = 8,
  parameter int               MAX_DELAY = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic              clk_i,
  input logic              rst_i,
  delay_line_prog_if.slave bus
);
  localparam int DW = $clog2(MAX_DELAY + 1);

  logic [WIDTH-1:0]     data_q  [1:MAX_DELAY];
  logic [WIDTH-1:0]     data_d  [1:MAX_DELAY];
  logic [MAX_DELAY:1]   valid_q;
  logic [MAX_DELAY:1]   valid_d;
  logic [DW-1:0]        tap_sel;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (bus.flush_i) begin
      for (int k = 1; k <= MAX_DELAY; k++) begin
        data_d[k] = RESET_VAL;
      end
      valid_d = '0;
    end else if (bus.en_i) begin
      data_d[1]  = bus.data_i;
      valid_d[1] = bus.valid_i;
      for (int k = 2; k <= MAX_DELAY; k++) begin
        data_d[k]  = data_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 1; k <= MAX_DELAY; k++) begin
        data_q[k] <= RESET_VAL;
      end
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Out-of-range selects saturate to the deepest stage so the tap can never index past the chain.
  always_comb begin
    tap_sel = bus.delay_i;
    if (bus.delay_i > DW'(MAX_DELAY)) begin
      tap_sel = DW'(MAX_DELAY);
    end
    bus.data_o  = bus.data_i;
    bus.valid_o = bus.valid_i;
    for (int k = 1; k <= MAX_DELAY; k++) begin
      if (tap_sel == DW'(k)) begin
        bus.data_o  = data_q[k];
        bus.valid_o = valid_q[k];
      end
    end
  end
endmodule

// File: tb/tb_delay_line_prog.sv
// Self-checking bench for delay_line_prog: reset, latency sweep, stall, flush, retap and clear priority.
// Fixed-tap scenarios use a FIFO scoreboard of expected {valid, data} entries; retap uses stream arithmetic.
module tb_delay_line_prog;
  localparam int         WIDTH     = 8;
  localparam int         MAX_DELAY = 4;
  localparam logic [7:0] RV        = 8'h5C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [8:0] sb_q[$];

  delay_line_prog_if #(.WIDTH(WIDTH), .DELAY_W(3)) bus ();

  delay_line_prog #(
    .WIDTH(WIDTH), .MAX_DELAY(MAX_DELAY), .RESET_VAL(RV)
  ) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // One cycle: drive at the falling edge, settle 1 time unit before any check.
  task automatic cycle(input logic en, input logic fl, input logic v, input logic [7:0] d);
    @(negedge clk);
    bus.en_i    = en;
    bus.flush_i = fl;
    bus.valid_i = v;
    bus.data_i  = d;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.en_i = 1'b1; bus.flush_i = 1'b0; bus.valid_i = 1'b1; bus.data_i = 8'hAA;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.en_i = 1'b0; bus.valid_i = 1'b0; bus.data_i = 8'h00;
    #1;
  endtask

  task automatic sb_clear(input int n);
    sb_q.delete();
    repeat (n) sb_q.push_back({1'b0, RV});
  endtask

  task automatic sb_capture(input int n, input logic v, input logic [7:0] d);
    if (n > 0) begin
      sb_q.push_back({v, d});
      void'(sb_q.pop_front());
    end
  endtask

  task automatic test_reset();
    bus.delay_i = 3'd3;
    do_reset();
    n_cmp++;
    if ({bus.valid_o, bus.data_o} !== {1'b0, RV}) begin
      n_bad++;
      $display("FAIL reset_out got=%h want=%h", {bus.valid_o, bus.data_o}, {1'b0, RV});
    end
    for (int c = 0; c < 5; c++) begin
      cycle(1'b1, 1'b0, 1'b0, RV);
      n_cmp++;
      if ({bus.valid_o, bus.data_o} !== {1'b0, RV}) begin
        n_bad++;
        $display("FAIL reset_hold c=%0d got=%h want=%h", c, {bus.valid_o, bus.data_o}, {1'b0, RV});
      end
    end
    bus.delay_i = 3'd0;
    cycle(1'b0, 1'b0, 1'b1, 8'h3A);
    n_cmp++;
    if ({bus.valid_o, bus.data_o} !== 9'h13A) begin
      n_bad++;
      $display("FAIL reset_bypass got=%h want=%h", {bus.valid_o, bus.data_o}, 9'h13A);
    end
  endtask

  task automatic test_latency();
    int sel [6] = '{0, 1, 2, 3, 4, 7};
    int neff;
    logic [8:0] exp;
    for (int i = 0; i < 6; i++) begin
      neff = (sel[i] > MAX_DELAY) ? MAX_DELAY : sel[i];
      bus.delay_i = 3'(sel[i]);
      do_reset();
      sb_clear(neff);
      for (int c = 0; c < 10; c++) begin
        cycle(1'b1, 1'b0, 1'b1, 8'(c + 1));
        exp = (neff == 0) ? {1'b1, 8'(c + 1)} : sb_q[0];
        n_cmp++;
        if ({bus.valid_o, bus.data_o} !== exp) begin
          n_bad++;
          $display("FAIL latency sel=%0d c=%0d got=%h want=%h", sel[i], c, {bus.valid_o, bus.data_o}, exp);
        end
        sb_capture(neff, 1'b1, 8'(c + 1));
      end
    end
  endtask

  task automatic test_stall();
    logic       en_s [9] = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
    logic [7:0] d_s  [9] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h11, 8'h12, 8'h13};
    logic [8:0] exp;
    bus.delay_i = 3'd2;
    do_reset();
    sb_clear(2);
    for (int c = 0; c < 9; c++) begin
      cycle(en_s[c], 1'b0, 1'b1, d_s[c]);
      exp = sb_q[0];
      n_cmp++;
      if ({bus.valid_o, bus.data_o} !== exp) begin
        n_bad++;
        $display("FAIL stall c=%0d got=%h want=%h", c, {bus.valid_o, bus.data_o}, exp);
      end
      n_cmp++;
      if (bus.valid_o === 1'b1 && (bus.data_o === 8'hC3 || bus.data_o === 8'hD4 || bus.data_o === 8'hE5)) begin
        n_bad++;
        $display("FAIL stall_leak c=%0d got=%h want=not C3/D4/E5", c, bus.data_o);
      end
      if (en_s[c]) sb_capture(2, 1'b1, d_s[c]);
    end
  endtask

  task automatic test_flush();
    logic [8:0] exp;
    bus.delay_i = 3'd3;
    do_reset();
    sb_clear(3);
    for (int c = 0; c < 5; c++) begin
      cycle(1'b1, 1'b0, 1'b1, 8'(8'h20 + c));
      sb_capture(3, 1'b1, 8'(8'h20 + c));
    end
    cycle(1'b1, 1'b1, 1'b1, 8'hEE);
    n_cmp++;
    if ({bus.valid_o, bus.data_o} !== sb_q[0]) begin
      n_bad++;
      $display("FAIL flush_pre got=%h want=%h", {bus.valid_o, bus.data_o}, sb_q[0]);
    end
    sb_clear(3);
    for (int c = 0; c < 7; c++) begin
      cycle(1'b1, 1'b0, 1'b1, 8'(8'h30 + c));
      exp = sb_q[0];
      n_cmp++;
      if ({bus.valid_o, bus.data_o} !== exp) begin
        n_bad++;
        $display("FAIL flush c=%0d got=%h want=%h", c, {bus.valid_o, bus.data_o}, exp);
      end
      n_cmp++;
      if (bus.data_o === 8'hEE) begin
        n_bad++;
        $display("FAIL flush_leak c=%0d got=%h want=not EE", c, bus.data_o);
      end
      sb_capture(3, 1'b1, 8'(8'h30 + c));
    end
  endtask

  // Stream 10+c from reset; tap schedule changes mid-stream, expected value is the input from c-N.
  task automatic test_retap();
    int n_a [12] = '{1, 1, 1, 1, 1, 1, 4, 4, 1, 1, 0, 2};
    int n_b [7]  = '{1, 1, 4, 4, 4, 4, 4};
    logic [8:0] exp;
    for (int r = 0; r < 2; r++) begin
      bus.delay_i = 3'd1;
      do_reset();
      for (int c = 0; c < ((r == 0) ? 12 : 7); c++) begin
        int n;
        n = (r == 0) ? n_a[c] : n_b[c];
        bus.delay_i = 3'(n);
        cycle(1'b1, 1'b0, 1'b1, 8'(10 + c));
        exp = (c < n) ? {1'b0, RV} : {1'b1, 8'(10 + c - n)};
        n_cmp++;
        if ({bus.valid_o, bus.data_o} !== exp) begin
          n_bad++;
          $display("FAIL retap r=%0d c=%0d N=%0d got=%h want=%h", r, c, n, {bus.valid_o, bus.data_o}, exp);
        end
      end
    end
  endtask

  task automatic test_priority();
    for (int r = 0; r < 2; r++) begin
      bus.delay_i = 3'd4;
      do_reset();
      for (int c = 0; c < 4; c++) cycle(1'b1, 1'b0, 1'b1, 8'(8'h40 + c));
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      n_cmp++;
      if ({bus.valid_o, bus.data_o} !== 9'h140) begin
        n_bad++;
        $display("FAIL prio_full r=%0d got=%h want=%h", r, {bus.valid_o, bus.data_o}, 9'h140);
      end
      // r=0: reset and flush together with enable; r=1: flush alone with enable low
      @(negedge clk);
      rst = (r == 0);
      bus.flush_i = 1'b1;
      bus.en_i = (r == 0);
      bus.valid_i = 1'b1;
      bus.data_i = 8'h77;
      @(negedge clk);
      rst = 1'b0;
      bus.flush_i = 1'b0;
      bus.en_i = 1'b0;
      for (int n = 1; n <= MAX_DELAY; n++) begin
        bus.delay_i = 3'(n);
        #1;
        n_cmp++;
        if ({bus.valid_o, bus.data_o} !== {1'b0, RV}) begin
          n_bad++;
          $display("FAIL prio_clear r=%0d N=%0d got=%h want=%h", r, n, {bus.valid_o, bus.data_o}, {1'b0, RV});
        end
      end
    end
  endtask

  initial begin
    bus.en_i = 1'b0; bus.flush_i = 1'b0; bus.valid_i = 1'b0;
    bus.data_i = 8'h00; bus.delay_i = 3'd0;
    test_reset();
    test_latency();
    test_stall();
    test_flush();
    test_retap();
    test_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
